// File: rtl/pcie_us_pkg.sv
// Shared definitions for the UltraScale PCIe completer: request types, completion
// status codes, descriptor field offsets and completion length helpers.
package pcie_us_pkg;

    localparam logic [3:0] REQ_MEM_RD = 4'b0000;
    localparam logic [3:0] REQ_MEM_WR = 4'b0001;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;

    // CQ beat 1 (DW2-3) field offsets
    localparam int CQ_DWCNT_LSB   = 0;
    localparam int CQ_REQTYPE_LSB = 11;
    localparam int CQ_REQID_LSB   = 16;
    localparam int CQ_TAG_LSB     = 32;
    localparam int CQ_TC_LSB      = 57;
    localparam int CQ_ATTR_LSB    = 60;

    // CC beat 0 (DW0-1) and beat 1 (DW2-3) field offsets
    localparam int CC_LADDR_LSB  = 0;
    localparam int CC_AT_LSB     = 8;
    localparam int CC_BCNT_LSB   = 16;
    localparam int CC_DWCNT_LSB  = 32;
    localparam int CC_STATUS_LSB = 43;
    localparam int CC_REQID_LSB  = 48;
    localparam int CC_TAG_LSB    = 0;
    localparam int CC_TC_LSB     = 25;
    localparam int CC_ATTR_LSB   = 28;
    localparam int CC_DATA_LSB   = 32;

    // Messages (11xx) are the only posted types besides MemWr.
    function automatic logic is_non_posted(input logic [3:0] req_type);
        return (req_type != REQ_MEM_WR) && (req_type[3:2] != 2'b11);
    endfunction

    function automatic logic [12:0] cpl_byte_count(input logic [3:0]  first_be,
                                                   input logic [10:0] dword_count,
                                                   input logic [2:0]  status);
        logic [12:0] bc;
        if (status != CPL_SC) begin
            bc = (dword_count == 11'd0) ? 13'd4096 : {dword_count, 2'b00};
        end else begin
            casez (first_be)
                4'b1??1:                   bc = 13'd4;
                4'b01?1, 4'b1?10:          bc = 13'd3;
                4'b0011, 4'b0110, 4'b1100: bc = 13'd2;
                default:                   bc = 13'd1;
            endcase
        end
        return bc;
    endfunction

    function automatic logic [1:0] cpl_be_offset(input logic [3:0] first_be,
                                                 input logic [2:0] status);
        logic [1:0] off;
        off = 2'd0;
        if (status == CPL_SC) begin
            if (first_be[0])      off = 2'd0;
            else if (first_be[1]) off = 2'd1;
            else if (first_be[2]) off = 2'd2;
            else if (first_be[3]) off = 2'd3;
        end
        return off;
    endfunction

endpackage

// File: rtl/pcie_us_cpl_len.sv
// Completion length helper: byte_count and the low two lower_addr bits for a
// single-DW success or an Unsupported Request completion.
module pcie_us_cpl_len
    import pcie_us_pkg::*;
(
    input  logic [3:0]  first_be,
    input  logic [10:0] dword_count,
    input  logic [2:0]  status,
    output logic [12:0] byte_count,
    output logic [1:0]  be_offset
);

    assign byte_count = cpl_byte_count(first_be, dword_count, status);
    assign be_offset  = cpl_be_offset(first_be, status);

endmodule

// File: rtl/pcie_us_cq_cc_completer.sv
// CQ -> CC completer with a small dword register file behind single-DW MemRd/MemWr.
// Define PCIE_US_COMPLETER_NP_FC_EN to gate pcie_cq_np_req while a completion is pending.
module pcie_us_cq_cc_completer
    import pcie_us_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 32,
    parameter int CQ_USER_WIDTH  = 85,
    parameter int CC_USER_WIDTH  = 33,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                     user_clk,
    input  logic                     user_reset,
    input  logic [DATA_WIDTH-1:0]    s_axis_cq_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
    input  logic                     s_axis_cq_tlast,
    output logic                     s_axis_cq_tready,
    input  logic [CQ_USER_WIDTH-1:0] s_axis_cq_tuser,
    input  logic                     s_axis_cq_tvalid,
    output logic [DATA_WIDTH-1:0]    m_axis_cc_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_cc_tkeep,
    output logic                     m_axis_cc_tlast,
    input  logic                     m_axis_cc_tready,
    output logic [CC_USER_WIDTH-1:0] m_axis_cc_tuser,
    output logic                     m_axis_cc_tvalid,
    output logic                     pcie_cq_np_req,
    output logic                     stat_ur
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR1  = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_CPL0  = 3'd4;
    localparam logic [2:0] ST_CPL1  = 3'd5;

    localparam int ADDR_HI   = (REG_ADDR_WIDTH + 1 > 6) ? REG_ADDR_WIDTH + 1 : 6;
    localparam int REG_DEPTH = 1 << REG_ADDR_WIDTH;

    logic [2:0]                state, state_nxt;
    logic                      cq_tready_r, stat_ur_r, hdr_ur, ur_r, wr_first_r;
    logic                      cq_fire, cc_fire, cpl_nxt;
    logic [ADDR_HI:2]          addr_r;
    logic [1:0]                at_r;
    logic [10:0]               dword_count_r;
    logic [15:0]               req_id_r;
    logic [7:0]                tag_r;
    logic [2:0]                tc_r, attr_r;
    logic [3:0]                first_be_r;
    logic [31:0]               rd_data_r;
    logic [31:0]               regs [REG_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] reg_idx;
    logic [3:0]                cq_req_type;
    logic [10:0]               cq_dword_count;
    logic [12:0]               byte_count;
    logic [1:0]                be_offset;
    logic [2:0]                cpl_status;
    logic [DATA_WIDTH-1:0]     cpl_beat0, cpl_beat1;
    logic                      unused_inputs;

    // Both streams use AXI-stream rules: a beat transfers on a clock edge where
    // tvalid and tready are both high; a source holds tvalid and data until then.
    assign cq_fire = s_axis_cq_tvalid && cq_tready_r;
    assign cc_fire = m_axis_cc_tvalid && m_axis_cc_tready;

    assign cq_req_type    = s_axis_cq_tdata[CQ_REQTYPE_LSB +: 4];
    assign cq_dword_count = s_axis_cq_tdata[CQ_DWCNT_LSB +: 11];
    assign reg_idx        = addr_r[REG_ADDR_WIDTH+1:2];
    assign cpl_nxt        = (state_nxt == ST_CPL0) || (state_nxt == ST_CPL1);
    assign cpl_status     = ur_r ? CPL_UR : CPL_SC;
    assign unused_inputs  = &{1'b0, s_axis_cq_tkeep, s_axis_cq_tuser, s_axis_cq_tdata};

    always_comb begin
        state_nxt = state;
        hdr_ur    = 1'b0;
        case (state)
            ST_IDLE:  if (cq_fire && !s_axis_cq_tlast) state_nxt = ST_HDR1;
            ST_HDR1: begin
                if (cq_fire) begin
                    if (cq_req_type == REQ_MEM_RD && cq_dword_count == 11'd1) begin
                        state_nxt = ST_CPL0;
                    end else if (cq_req_type == REQ_MEM_WR) begin
                        state_nxt = ST_WDATA;
                    end else if (is_non_posted(cq_req_type)) begin
                        hdr_ur    = 1'b1;
                        state_nxt = ST_CPL0;
                    end else begin
                        hdr_ur    = 1'b1;
                        state_nxt = s_axis_cq_tlast ? ST_IDLE : ST_DRAIN;
                    end
                end
            end
            ST_WDATA, ST_DRAIN: if (cq_fire && s_axis_cq_tlast) state_nxt = ST_IDLE;
            ST_CPL0:  if (cc_fire) state_nxt = ST_CPL1;
            ST_CPL1:  if (cc_fire) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state         <= ST_IDLE;
            cq_tready_r   <= 1'b0;
            stat_ur_r     <= 1'b0;
            ur_r          <= 1'b0;
            wr_first_r    <= 1'b0;
            addr_r        <= '0;
            at_r          <= '0;
            dword_count_r <= '0;
            req_id_r      <= '0;
            tag_r         <= '0;
            tc_r          <= '0;
            attr_r        <= '0;
            first_be_r    <= '0;
            rd_data_r     <= '0;
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            state       <= state_nxt;
            cq_tready_r <= !cpl_nxt;
            stat_ur_r   <= hdr_ur;
            if (state == ST_IDLE && cq_fire) begin
                addr_r <= s_axis_cq_tdata[ADDR_HI:2];
                at_r   <= s_axis_cq_tdata[1:0];
            end
            if (state == ST_HDR1 && cq_fire) begin
                dword_count_r <= cq_dword_count;
                req_id_r      <= s_axis_cq_tdata[CQ_REQID_LSB +: 16];
                tag_r         <= s_axis_cq_tdata[CQ_TAG_LSB +: 8];
                tc_r          <= s_axis_cq_tdata[CQ_TC_LSB +: 3];
                attr_r        <= s_axis_cq_tdata[CQ_ATTR_LSB +: 3];
                first_be_r    <= s_axis_cq_tuser[3:0];
                ur_r          <= hdr_ur;
                wr_first_r    <= 1'b1;
                rd_data_r     <= regs[reg_idx];
            end
            // Only a single-DW write lands; longer bursts are consumed and discarded.
            if (state == ST_WDATA && cq_fire) begin
                wr_first_r <= 1'b0;
                if (wr_first_r && dword_count_r == 11'd1) begin
                    for (int b = 0; b < 4; b++) begin
                        if (first_be_r[b]) regs[reg_idx][8*b +: 8] <= s_axis_cq_tdata[8*b +: 8];
                    end
                end
            end
        end
    end

    pcie_us_cpl_len u_cpl_len (
        .first_be    (first_be_r),
        .dword_count (dword_count_r),
        .status      (cpl_status),
        .byte_count  (byte_count),
        .be_offset   (be_offset)
    );

    always_comb begin
        cpl_beat0 = '0;
        cpl_beat1 = '0;
        cpl_beat0[CC_LADDR_LSB +: 7]  = {addr_r[6:2], be_offset};
        cpl_beat0[CC_AT_LSB +: 2]     = at_r;
        cpl_beat0[CC_BCNT_LSB +: 13]  = byte_count;
        cpl_beat0[CC_DWCNT_LSB +: 11] = ur_r ? 11'd0 : 11'd1;
        cpl_beat0[CC_STATUS_LSB +: 3] = cpl_status;
        cpl_beat0[CC_REQID_LSB +: 16] = req_id_r;
        cpl_beat1[CC_TAG_LSB +: 8]    = tag_r;
        cpl_beat1[CC_TC_LSB +: 3]     = tc_r;
        cpl_beat1[CC_ATTR_LSB +: 3]   = attr_r;
        cpl_beat1[CC_DATA_LSB +: 32]  = ur_r ? 32'd0 : rd_data_r;
    end

    always_comb begin
        m_axis_cc_tdata = '0;
        if (state == ST_CPL0)      m_axis_cc_tdata = cpl_beat0;
        else if (state == ST_CPL1) m_axis_cc_tdata = cpl_beat1;
    end

    assign m_axis_cc_tvalid = (state == ST_CPL0) || (state == ST_CPL1);
    assign m_axis_cc_tlast  = (state == ST_CPL1);
    assign m_axis_cc_tkeep  = {KEEP_WIDTH{m_axis_cc_tvalid}};
    assign m_axis_cc_tuser  = '0;
    assign s_axis_cq_tready = cq_tready_r;
    assign stat_ur          = stat_ur_r;

`ifdef PCIE_US_COMPLETER_NP_FC_EN
    logic np_req_r;
    always_ff @(posedge user_clk) begin
        if (user_reset) np_req_r <= 1'b1;
        else            np_req_r <= !cpl_nxt;
    end
    assign pcie_cq_np_req = np_req_r;
`else
    assign pcie_cq_np_req = 1'b1;
`endif

endmodule

// File: tb/tb_pcie_us_cq_cc_completer.sv
// Randomized scoreboard bench for pcie_us_cq_cc_completer: a request-level model
// pushes expected CC beats, and a monitor pops them on every CC handshake.
module tb_pcie_us_cq_cc_completer;

    localparam int W = 67;

    logic        user_clk = 1'b0;
    logic        user_reset = 1'b1;
    logic [63:0] s_axis_cq_tdata = '0;
    logic [1:0]  s_axis_cq_tkeep = '0;
    logic        s_axis_cq_tlast = 1'b0;
    logic        s_axis_cq_tready;
    logic [84:0] s_axis_cq_tuser = '0;
    logic        s_axis_cq_tvalid = 1'b0;
    logic [63:0] m_axis_cc_tdata;
    logic [1:0]  m_axis_cc_tkeep;
    logic        m_axis_cc_tlast;
    logic        m_axis_cc_tready = 1'b1;
    logic [32:0] m_axis_cc_tuser;
    logic        m_axis_cc_tvalid;
    logic        pcie_cq_np_req;
    logic        stat_ur;

    logic [W-1:0] exp_q[$];
    logic [31:0]  mem [16];
    int           checks = 0;
    int           errors = 0;
    int           ur_exp = 0;
    int           ur_seen = 0;
    bit           bp_en = 1'b0;

    pcie_us_cq_cc_completer dut (
        .user_clk         (user_clk),
        .user_reset       (user_reset),
        .s_axis_cq_tdata  (s_axis_cq_tdata),
        .s_axis_cq_tkeep  (s_axis_cq_tkeep),
        .s_axis_cq_tlast  (s_axis_cq_tlast),
        .s_axis_cq_tready (s_axis_cq_tready),
        .s_axis_cq_tuser  (s_axis_cq_tuser),
        .s_axis_cq_tvalid (s_axis_cq_tvalid),
        .m_axis_cc_tdata  (m_axis_cc_tdata),
        .m_axis_cc_tkeep  (m_axis_cc_tkeep),
        .m_axis_cc_tlast  (m_axis_cc_tlast),
        .m_axis_cc_tready (m_axis_cc_tready),
        .m_axis_cc_tuser  (m_axis_cc_tuser),
        .m_axis_cc_tvalid (m_axis_cc_tvalid),
        .pcie_cq_np_req   (pcie_cq_np_req),
        .stat_ur          (stat_ur)
    );

    // ---------------- clock / watchdog ----------------
    always #5 user_clk = ~user_clk;

    initial begin
        #800000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void push_cpl(input bit ur, input logic [63:0] addr, input logic [1:0] at,
                                     input logic [10:0] dc, input logic [3:0] fbe,
                                     input logic [15:0] rid, input logic [7:0] tag,
                                     input logic [2:0] tc, input logic [2:0] attr,
                                     input logic [31:0] data);
        int lo, hi, bc;
        logic [6:0]  la;
        logic [63:0] e0, e1;
        lo = -1;
        hi = 0;
        if (ur) begin
            bc = (dc == 11'd0) ? 4096 : int'(dc) * 4;
            la = {addr[6:2], 2'b00};
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (fbe[i]) begin
                    if (lo < 0) lo = i;
                    hi = i;
                end
            end
            if (lo < 0) begin
                bc = 1;
                lo = 0;
            end else begin
                bc = hi - lo + 1;
            end
            la = {addr[6:2], 2'(lo)};
        end
        e0 = '0;
        e0[6:0]   = la;
        e0[9:8]   = at;
        e0[28:16] = 13'(bc);
        e0[42:32] = ur ? 11'd0 : 11'd1;
        e0[45:43] = ur ? 3'b001 : 3'b000;
        e0[63:48] = rid;
        e1 = '0;
        e1[7:0]   = tag;
        e1[27:25] = tc;
        e1[30:28] = attr;
        e1[63:32] = ur ? 32'd0 : data;
        exp_q.push_back({1'b0, 2'b11, e0});
        exp_q.push_back({1'b1, 2'b11, e1});
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cq_beat(input logic [63:0] d, input logic [3:0] fbe, input logic last);
        bit acc;
        int n;
        s_axis_cq_tdata        = d;
        s_axis_cq_tkeep        = 2'b11;
        s_axis_cq_tuser        = '0;
        s_axis_cq_tuser[3:0]   = fbe;
        s_axis_cq_tuser[7:4]   = 4'($urandom);
        s_axis_cq_tlast        = last;
        s_axis_cq_tvalid       = 1'b1;
        n = 0;
        do begin
            acc = s_axis_cq_tready;
            @(posedge user_clk);
            #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL cq_accept actual=timeout required=accept");
        end
        s_axis_cq_tvalid = 1'b0;
        s_axis_cq_tlast  = 1'b0;
    endtask

    task automatic send_req(input logic [3:0] rt, input logic [63:0] addr, input logic [10:0] dc,
                            input logic [3:0] fbe, input int npl, input logic [31:0] wdata,
                            input logic [7:0] tag);
        logic [15:0] rid;
        logic [2:0]  tc, attr;
        logic [1:0]  at;
        logic [63:0] b0, b1;
        int          idx;
        bit          posted;
        rid    = 16'($urandom);
        tc     = 3'($urandom);
        attr   = 3'($urandom);
        at     = 2'($urandom);
        idx    = int'(addr[5:2]);
        b0     = {addr[63:2], at};
        b1     = {1'b0, attr, tc, 6'($urandom), 3'($urandom), 8'($urandom), tag, rid, 1'b0, rt, dc};
        posted = rt inside {4'b0001, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        if (rt == 4'b0000 && dc == 11'd1) begin
            push_cpl(1'b0, addr, at, dc, fbe, rid, tag, tc, attr, mem[idx]);
        end else if (!posted) begin
            push_cpl(1'b1, addr, at, dc, fbe, rid, tag, tc, attr, 32'd0);
            ur_exp++;
        end else if (rt != 4'b0001) begin
            ur_exp++;
        end
        cq_beat(b0, fbe, 1'b0);
        cq_beat(b1, fbe, npl == 0);
        for (int p = 0; p < npl; p++)
            cq_beat({32'($urandom), (p == 0) ? wdata : 32'($urandom)}, fbe, p == npl - 1);
        if (rt == 4'b0001 && dc == 11'd1 && npl > 0) begin
            for (int b = 0; b < 4; b++)
                if (fbe[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge user_clk);
            #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- CC backpressure ----------------
    initial forever begin
        @(posedge user_clk);
        #1;
        if (bp_en) m_axis_cc_tready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge user_clk) begin
        if (!user_reset) begin
            if (stat_ur) ur_seen++;
            if (m_axis_cc_tvalid && m_axis_cc_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cc_unexpected actual=%0h required=no_beat",
                             {m_axis_cc_tlast, m_axis_cc_tkeep, m_axis_cc_tdata});
                end else begin
                    chk("cc_beat", {m_axis_cc_tlast, m_axis_cc_tkeep, m_axis_cc_tdata}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] ra;
        logic [3:0]  rt;
        logic [10:0] dc;
        int          k;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;

        repeat (3) @(posedge user_clk);
        #1;
        chk("rst_cq_tready", s_axis_cq_tready, 0);
        chk("rst_cc_tvalid", m_axis_cc_tvalid, 0);
        chk("rst_cc_tlast", m_axis_cc_tlast, 0);
        chk("rst_cc_tdata", m_axis_cc_tdata, 0);
        chk("rst_cc_tkeep", m_axis_cc_tkeep, 0);
        chk("rst_stat_ur", stat_ur, 0);
        user_reset = 1'b0;
        @(posedge user_clk);
        #1;
        chk("cq_tready_after_reset", s_axis_cq_tready, 1);
        chk("np_req_idle", pcie_cq_np_req, 1);
        bp_en = 1'b1;

        // directed cases
        send_req(4'b0001, 64'h8, 11'd1, 4'hF, 1, 32'hDEADBEEF, 8'h01);
        send_req(4'b0000, 64'h8, 11'd1, 4'hF, 0, 32'd0, 8'h12);
        send_req(4'b0000, 64'h4, 11'd1, 4'h2, 0, 32'd0, 8'h21);
        send_req(4'b0000, 64'h10, 11'd4, 4'hF, 0, 32'd0, 8'h22);
        send_req(4'b0000, 64'h10, 11'd0, 4'hF, 0, 32'd0, 8'h23);
        send_req(4'b0001, 64'h8, 11'd3, 4'hF, 2, 32'h12345678, 8'h24);
        send_req(4'b0000, 64'h8, 11'd1, 4'hF, 0, 32'd0, 8'h25);
        cq_beat(64'h20, 4'hF, 1'b1);
        send_req(4'b0000, 64'hFFFF_0000_0000_0048, 11'd1, 4'hC, 0, 32'd0, 8'h26);
        send_req(4'b1100, 64'h0, 11'd2, 4'h0, 3, 32'd0, 8'h27);
        send_req(4'b1000, 64'h0, 11'd1, 4'hF, 0, 32'd0, 8'h28);

        // randomized mix
        for (int it = 0; it < 250; it++) begin
            ra = {$urandom, $urandom};
            k  = $urandom_range(0, 7);
            case (k)
                0, 1: send_req(4'b0000, ra, 11'd1, 4'($urandom), 0, 32'd0, 8'($urandom));
                2:    send_req(4'b0001, ra, 11'd1, 4'($urandom), 1, $urandom, 8'($urandom));
                3: begin
                    dc = 11'($urandom_range(2, 8));
                    send_req(4'b0001, ra, dc, 4'($urandom), (int'(dc) + 1) / 2, $urandom, 8'($urandom));
                end
                4: begin
                    dc = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(2, 2047));
                    send_req(4'b0000, ra, dc, 4'($urandom), 0, 32'd0, 8'($urandom));
                end
                5: begin
                    case ($urandom_range(0, 3))
                        0:       rt = 4'b0010;
                        1:       rt = 4'b0111;
                        2:       rt = 4'b1000;
                        default: rt = 4'b1001;
                    endcase
                    send_req(rt, ra, 11'($urandom_range(1, 4)), 4'($urandom), 0, 32'd0, 8'($urandom));
                end
                6: send_req(4'($urandom_range(12, 15)), ra, 11'd0, 4'h0, $urandom_range(0, 3), 32'd0, 8'($urandom));
                default: cq_beat(ra, 4'($urandom), 1'b1);
            endcase
        end
        drain();

        // held completion under backpressure, then reset during CPL1
        bp_en = 1'b0;
        m_axis_cc_tready = 1'b0;
        send_req(4'b0000, 64'h8, 11'd1, 4'hF, 0, 32'd0, 8'h33);
        chk("cpl0_latency_valid", m_axis_cc_tvalid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_beat", {m_axis_cc_tlast, m_axis_cc_tkeep, m_axis_cc_tdata}, exp_q[0]);
            chk("stall_cq_tready", s_axis_cq_tready, 0);
`ifdef PCIE_US_COMPLETER_NP_FC_EN
            chk("stall_np_req", pcie_cq_np_req, 0);
`else
            chk("stall_np_req", pcie_cq_np_req, 1);
`endif
            @(posedge user_clk);
            #1;
        end
        m_axis_cc_tready = 1'b1;
        @(posedge user_clk);
        #1;
        m_axis_cc_tready = 1'b0;
        chk("cpl1_hold", {m_axis_cc_tlast, m_axis_cc_tkeep, m_axis_cc_tdata}, exp_q[0]);
        user_reset = 1'b1;
        void'(exp_q.pop_front());
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        @(posedge user_clk);
        #1;
        chk("reset_cc_tvalid", m_axis_cc_tvalid, 0);
        chk("reset_cc_tdata", m_axis_cc_tdata, 0);
        chk("reset_cq_tready", s_axis_cq_tready, 0);
        user_reset = 1'b0;
        m_axis_cc_tready = 1'b1;
        @(posedge user_clk);
        #1;
        chk("cq_tready_after_midreset", s_axis_cq_tready, 1);
        bp_en = 1'b1;
        send_req(4'b0000, 64'h8, 11'd1, 4'hF, 0, 32'd0, 8'h34);
        drain();
        repeat (4) @(posedge user_clk);
        #1;

        chk("stat_ur_count", ur_seen, ur_exp);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
